// File: rtl/analog_ctrl_pkg.sv
// Shared definitions for the analog switch controller: sequencer states and
// register map constants.
package analog_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBreak = 2'd1,
    StMake  = 2'd2
  } sw_state_e;

  localparam int unsigned STATUS_OFS = 15;
  localparam int unsigned ENABLE_BIT = 8;

endpackage

// File: rtl/switch_seq.sv
// One analog switch channel: break-before-make sequencer with dead-time counter.
// Outputs are registered so a slice never shows more than one enable.
module switch_seq
  import analog_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DEAD_CYC = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_i,
  input  logic                    en_i,
  input  logic [SEL_W-1:0]        target_i,
  output logic [(1<<SEL_W)-1:0]   sw_en_o,
  output logic                    busy_o
);

  localparam int unsigned NSW      = 1 << SEL_W;
  localparam logic [7:0]  CNT_LOAD = 8'(DEAD_CYC - 1);

  sw_state_e        state_q;
  logic [7:0]       cnt_q;
  logic [SEL_W-1:0] cur_q;
  logic             act_q;
  logic [NSW-1:0]   sw_q;
  logic             busy_q;

  function automatic logic [NSW-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NSW-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= '0;
      act_q   <= 1'b0;
      sw_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_i) begin
            if (!en_i) begin
              sw_q  <= '0;
              act_q <= 1'b0;
            end else if (!act_q || (target_i != cur_q)) begin
              state_q <= StBreak;
              cnt_q   <= CNT_LOAD;
              sw_q    <= '0;
              busy_q  <= 1'b1;
              act_q   <= 1'b1;
            end
          end
        end
        StBreak: begin
          if (wr_i && !en_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sw_q    <= '0;
            busy_q  <= 1'b0;
            act_q   <= 1'b0;
          end else if (cnt_q == 8'd0) begin
            // Latest target is sampled here, so writes during BREAK are honoured.
            state_q <= StMake;
            sw_q    <= onehot(target_i);
            cur_q   <= target_i;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StMake: begin
          if (wr_i && !en_i) begin
            state_q <= StIdle;
            sw_q    <= '0;
            busy_q  <= 1'b0;
            act_q   <= 1'b0;
          end else if (wr_i && (target_i != cur_q)) begin
            state_q <= StBreak;
            cnt_q   <= CNT_LOAD;
            sw_q    <= '0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          sw_q    <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sw_en_o = sw_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/analog_switch_ctrl.sv
// Wishbone-controlled bank of break-before-make analog switch channels.
// CFG registers at word offsets 0..NUM_CH-1, STATUS (busy) at offset 15.
module analog_switch_ctrl
  import analog_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DEAD_CYC = 8
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic [31:0]                    wbs_dat_o,
  output logic                           wbs_ack_o,
  output logic [NUM_CH*(1<<SEL_W)-1:0]   sw_en_o,
  output logic [NUM_CH-1:0]              busy_o
);

  localparam int unsigned NSW = 1 << SEL_W;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, rdata;
  logic [SEL_W-1:0] sel_q [NUM_CH];
  logic [NUM_CH-1:0] en_q, wr_q, busy;
  logic [3:0]       ofs;
  logic             unused_bits;

  assign ofs         = wbs_adr_i[5:2];
  assign unused_bits = ^{wbs_adr_i[31:6], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i};

  // Ack is suppressed right after an ack so a held strobe gets 0,1,0,1,...
  assign ack_d = wbs_cyc_i & wbs_stb_i & ~ack_q;

  always_comb begin
    rdata = '0;
    if (ofs == 4'(STATUS_OFS)) begin
      rdata[NUM_CH-1:0] = busy;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ofs == 4'(n)) begin
          rdata[SEL_W-1:0]  = sel_q[n];
          rdata[ENABLE_BIT] = en_q[n];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      en_q  <= '0;
      wr_q  <= '0;
      for (int n = 0; n < NUM_CH; n++) sel_q[n] <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= (ack_d && !wbs_we_i) ? rdata : 32'd0;
      wr_q  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        if (ack_d && wbs_we_i && (ofs == 4'(n))) begin
          wr_q[n] <= 1'b1;
          if (wbs_sel_i[0]) sel_q[n] <= wbs_dat_i[SEL_W-1:0];
          if (wbs_sel_i[1]) en_q[n]  <= wbs_dat_i[ENABLE_BIT];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    switch_seq #(
      .SEL_W    (SEL_W),
      .DEAD_CYC (DEAD_CYC)
    ) u_seq (
      .clk_i    (wb_clk_i),
      .rst_ni   (wb_rst_ni),
      .wr_i     (wr_q[g]),
      .en_i     (en_q[g]),
      .target_i (sel_q[g]),
      .sw_en_o  (sw_en_o[g*NSW +: NSW]),
      .busy_o   (busy[g])
    );
  end

  assign busy_o    = busy;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_analog_switch_ctrl.sv
// Directed bench for analog_switch_ctrl (NUM_CH=4, SEL_W=2, DEAD_CYC=8).
module tb_analog_switch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  bsel;
  logic [31:0] adr, wdat, rdat;
  logic        ack;
  logic [15:0] sw;
  logic [3:0]  busy;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int onehot_viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  analog_switch_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (bsel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (rdat),
    .wbs_ack_o (ack),
    .sw_en_o   (sw),
    .busy_o    (busy)
  );

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) if ($countones(sw[c*4 +: 4]) > 1) onehot_viol++;
  end

  typedef struct {
    logic [3:0]  ofs;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [3:0] ofs, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    bit got;
    got = 0;
    r   = '0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = {26'd0, ofs, 2'b00}; wdat = d; bsel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1;
        r   = rdat;
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [3:0] ofs, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, ofs, d, s, r);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 64 && cyc_cnt < t; i++) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs [8];
  logic [31:0] r;
  int t0;

  initial begin
    cyc = 0; stb = 0; we = 0; bsel = 0; adr = 0; wdat = 0;
    rst_n = 0;
    tick(3);
    check("reset_sw", {16'd0, sw}, 32'd0);
    check("reset_busy", {28'd0, busy}, 32'd0);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_dat", rdat, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Basic enable with select 1
    wr(4'd0, 32'h101, 4'h3);
    check("a_t0_busy", {31'd0, busy[0]}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("a_break_busy", {31'd0, busy[0]}, 32'd1);
      check("a_break_sw", {28'd0, sw[3:0]}, 32'd0);
    end
    tick(1);
    check("a_make_busy", {31'd0, busy[0]}, 32'd1);
    check("a_make_sw", {28'd0, sw[3:0]}, 32'h2);
    tick(1);
    check("a_idle_busy", {31'd0, busy[0]}, 32'd0);
    check("a_idle_sw", {28'd0, sw[3:0]}, 32'h2);

    // Channel 1: enable at 0, then switch to 3
    wr(4'd1, 32'h100, 4'h3);
    tick(8);
    check("b_first_break", {28'd0, sw[7:4]}, 32'h0);
    tick(1);
    check("b_first_make", {28'd0, sw[7:4]}, 32'h1);
    tick(3);
    wr(4'd1, 32'h103, 4'h3);
    check("b_t0", {28'd0, sw[7:4]}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("b_break_sw", {28'd0, sw[7:4]}, 32'h0);
    end
    tick(1);
    check("b_make_sw", {28'd0, sw[7:4]}, 32'h8);
    tick(1);
    check("b_same_target_sw", {28'd0, sw[7:4]}, 32'h8);
    wr(4'd1, 32'h103, 4'h3);
    tick(1);
    check("b_same_no_seq_busy", {31'd0, busy[1]}, 32'd0);
    check("b_same_no_glitch", {28'd0, sw[7:4]}, 32'h8);

    // Target rewrite during BREAK keeps original timing
    wr(4'd0, 32'h103, 4'h3);
    t0 = cyc_cnt;
    tick(2);
    wr(4'd0, 32'h102, 4'h1);
    wait_until(t0 + 8);
    check("c_late_break_sw", {28'd0, sw[3:0]}, 32'h0);
    check("c_late_break_busy", {31'd0, busy[0]}, 32'd1);
    tick(1);
    check("c_make_sw", {28'd0, sw[3:0]}, 32'h4);
    tick(2);

    // Disable during BREAK
    wr(4'd0, 32'h103, 4'h3);
    tick(2);
    wr(4'd0, 32'h000, 4'h3);
    tick(1);
    check("d_sw_off", {28'd0, sw[3:0]}, 32'h0);
    check("d_busy_off", {31'd0, busy[0]}, 32'd0);
    wb_xfer(1'b0, 4'd15, 32'd0, 4'hF, r);
    check("d_status", r, 32'd0);
    tick(12);
    check("d_stays_off", {28'd0, sw[3:0]}, 32'h0);

    // Held strobe: ack alternates
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'd12 << 2; bsel = 4'hF;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("e_ack_pattern", {31'd0, ack}, {31'd0, 1'(i % 2)});
      check("e_unmapped_read", rdat, 32'd0);
      if (i < 5) tick(1);
    end
    cyc = 0; stb = 0;
    tick(2);

    // Register access table: write then read back
    vecs[0] = '{4'd2,  32'h1FF,  4'hF, 32'h103};
    vecs[1] = '{4'd2,  32'h000,  4'h1, 32'h100};
    vecs[2] = '{4'd2,  32'h000,  4'h2, 32'h000};
    vecs[3] = '{4'd3,  32'h102,  4'h3, 32'h102};
    vecs[4] = '{4'd3,  32'h001,  4'h1, 32'h101};
    vecs[5] = '{4'd12, 32'hFFFF, 4'hF, 32'h000};
    vecs[6] = '{4'd7,  32'hFFFF, 4'hF, 32'h000};
    vecs[7] = '{4'd3,  32'h000,  4'hF, 32'h000};
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].ofs, vecs[i].wdata, vecs[i].bsel);
      wb_xfer(1'b0, vecs[i].ofs, 32'd0, 4'hF, r);
      check($sformatf("tbl_readback_%0d", i), r, vecs[i].exp);
    end
    tick(12);
    wb_xfer(1'b0, 4'd1, 32'd0, 4'hF, r);
    check("tbl_cfg1", r, 32'h103);

    // Reset mid-BREAK
    wr(4'd0, 32'h101, 4'h3);
    tick(3);
    rst_n = 0;
    #1;
    check("f_rst_sw", {16'd0, sw}, 32'd0);
    check("f_rst_busy", {28'd0, busy}, 32'd0);
    check("f_rst_ack", {31'd0, ack}, 32'd0);
    tick(2);
    @(negedge clk);
    rst_n = 1;
    wb_xfer(1'b0, 4'd0, 32'd0, 4'hF, r);
    check("f_cfg0_cleared", r, 32'd0);
    wb_xfer(1'b0, 4'd1, 32'd0, 4'hF, r);
    check("f_cfg1_cleared", r, 32'd0);
    tick(12);
    check("f_no_resume_sw", {16'd0, sw}, 32'd0);
    check("f_no_resume_busy", {28'd0, busy}, 32'd0);

    check("onehot_invariant", onehot_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/analog_switch_ctrl.md
ANALOG_SWITCH_CTRL -- requirements
Module: analog_switch_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent analog switch channels (1..15).
REQ-002 SHALL have parameter SEL_W, default 2, select width; each channel drives 2**SEL_W switch enables.
REQ-003 SHALL have parameter DEAD_CYC, default 8, break-before-make dead time in clocks (1..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, listed first:
  wb_clk_i  in  1  clock, all logic on rising edge
  wb_rst_ni  in  1  asynchronous active-low reset
  wbs_cyc_i  in  1  Wishbone cycle
  wbs_stb_i  in  1  Wishbone strobe
  wbs_we_i  in  1  write enable
  wbs_sel_i  in  4  byte selects
  wbs_adr_i  in  32  byte address; only [5:2] decoded
  wbs_dat_i  in  32  write data
  wbs_dat_o  out  32  read data
  wbs_ack_o  out  1  transfer acknowledge
  sw_en_o  out  NUM_CH*2**SEL_W  switch enables; channel n owns slice [n*2**SEL_W +: 2**SEL_W]
  busy_o  out  NUM_CH  channel n mid-sequence

Function
REQ-005 SHALL decode wbs_adr_i[5:2]=n (n<NUM_CH) as CFG[n]: bits [SEL_W-1:0] target select, bit 8 enable, other bits read 0.
REQ-006 SHALL decode wbs_adr_i[5:2]=15 as STATUS: bits [NUM_CH-1:0] = busy_o, read-only, writes ignored.
REQ-007 SHALL return 0 on reads of unmapped offsets and ignore writes to them.
REQ-008 SHALL assert wbs_ack_o for exactly one cycle, registered, the cycle after cyc&stb first seen; ack SHALL NOT be asserted in the cycle immediately following an ack (no back-to-back acks on a held strobe).
REQ-009 SHALL update select only when wbs_sel_i[0]=1 and enable only when wbs_sel_i[1]=1; write takes effect on the ack cycle.
REQ-010 SHALL drive wbs_dat_o valid in the ack cycle, 0 otherwise.
REQ-011 Per-channel FSM states SHALL be IDLE, BREAK, MAKE.
REQ-012 IDLE: output = one-hot(current select) if enabled, else all zero; busy=0.
REQ-013 IDLE->BREAK when enable=1 and written target differs from current select, or enable rises 0->1; dead counter loads DEAD_CYC-1.
REQ-014 BREAK: channel outputs all zero, busy=1, counter decrements each clock; at counter=0 go to MAKE.
REQ-015 MAKE (one cycle): output = one-hot(latest target), current select := target, busy=1; next IDLE.
REQ-016 A target write during BREAK SHALL update the target without restarting the counter; MAKE uses the latest value.
REQ-017 Write with enable=0 SHALL force outputs zero in the next cycle and return the FSM to IDLE from any state; no dead time.
REQ-018 Write of same target with enable=1 while IDLE SHALL cause no sequence and no output glitch.
REQ-019 At most one bit per channel slice of sw_en_o SHALL ever be 1; no two selects ever simultaneously on.
REQ-020 Channels SHALL sequence independently and concurrently.
REQ-021 Total switch latency from ack to new output = DEAD_CYC+1 clocks.

Reset
REQ-022 On wb_rst_ni=0 SHALL asynchronously clear: sw_en_o=0, busy_o=0, wbs_ack_o=0, wbs_dat_o=0, all CFG=0, all FSMs IDLE, counters 0.
REQ-023 Reset asserted mid-BREAK SHALL leave outputs zero; after release no sequence resumes.

Structure
REQ-024 Shared package analog_ctrl_pkg SHALL hold state enum (IDLE/BREAK/MAKE), register offsets (STATUS_OFS=15), CFG field positions (ENABLE_BIT=8).
REQ-025 One sub-module switch_seq (one channel FSM + dead counter) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-026 Reset, write CFG[0]=0x101 -> busy_o[0]=1 for 9 cycles, sw_en_o[3:0]=0 for 8 cycles, then 4'b0010.
REQ-027 CFG[1]=0x100 then 0x103 after settle -> slice[7:4] goes 0001, 0000 for 8 cycles, 1000; never two bits set.
REQ-028 During CFG[0] BREAK, write 0x102 -> counter not restarted, MAKE drives 0100 at original time.
REQ-029 During BREAK write CFG[0]=0x000 -> slice 0 zero next cycle, busy_o[0]=0; read STATUS returns 0.
REQ-030 Held cyc&stb for 6 cycles -> ack pattern 0,1,0,1,0,1; read offset 12 (NUM_CH=4) -> 0.
REQ-031 Pull wb_rst_ni low mid-BREAK -> all outputs 0 immediately; CFG reads 0 after release.
